// File: rtl/rob_if.sv
// Reorder-buffer bus: dispatch request/grant, CDB completion and retire
// signals bundled between the decode/rename side (master) and the ROB (slave).
interface rob_if #(
  parameter int IDX_W = 5,
  parameter int TAG_W = 7
);
  logic [1:0]       id_dispatch_num;
  logic [TAG_W-1:0] fl_tag_a;
  logic [TAG_W-1:0] fl_tag_b;
  logic [TAG_W-1:0] mt_old_tag_a;
  logic [TAG_W-1:0] mt_old_tag_b;
  logic             cdb_valid_a;
  logic             cdb_valid_b;
  logic [IDX_W-1:0] cdb_idx_a;
  logic [IDX_W-1:0] cdb_idx_b;

  logic [1:0]       rob_dispatch_num;
  logic [IDX_W-1:0] rob_idx_a;
  logic [IDX_W-1:0] rob_idx_b;
  logic [1:0]       rob_retire_num;
  logic [TAG_W-1:0] rob_retire_a;
  logic [TAG_W-1:0] rob_retire_b;
  logic             rob_full;
  logic             rob_empty;
  logic [IDX_W:0]   rob_count;

  modport slave (
    input  id_dispatch_num, fl_tag_a, fl_tag_b, mt_old_tag_a, mt_old_tag_b,
           cdb_valid_a, cdb_valid_b, cdb_idx_a, cdb_idx_b,
    output rob_dispatch_num, rob_idx_a, rob_idx_b, rob_retire_num,
           rob_retire_a, rob_retire_b, rob_full, rob_empty, rob_count
  );

  modport master (
    output id_dispatch_num, fl_tag_a, fl_tag_b, mt_old_tag_a, mt_old_tag_b,
           cdb_valid_a, cdb_valid_b, cdb_idx_a, cdb_idx_b,
    input  rob_dispatch_num, rob_idx_a, rob_idx_b, rob_retire_num,
           rob_retire_a, rob_retire_b, rob_full, rob_empty, rob_count
  );
endinterface

// File: rtl/rob.sv
// Two-wide reorder buffer: circular buffer of ROB_SIZE entries, in-order
// dispatch at the tail, out-of-order completion from two CDB ports, and
// in-order retirement of up to two entries per cycle from the head.
module rob #(
  parameter int ROB_SIZE = 32,
  parameter int IDX_W    = 5,
  parameter int TAG_W    = 7
) (
  input logic clock,
  input logic reset,
  rob_if.slave bus
);

  localparam logic [IDX_W:0] SIZE_C = (IDX_W+1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0] valid_q, valid_d;
  logic [ROB_SIZE-1:0] complete_q, complete_d;
  logic [TAG_W-1:0]    new_tag_q [ROB_SIZE];
  logic [TAG_W-1:0]    old_tag_q [ROB_SIZE];
  logic [IDX_W-1:0]    head_q, head_d;
  logic [IDX_W-1:0]    tail_q, tail_d;
  logic [IDX_W:0]      count_q, count_d;

  logic [IDX_W-1:0]    head1;
  logic [IDX_W-1:0]    tail1;
  logic [IDX_W:0]      free_slots;
  logic [1:0]          req;
  logic [1:0]          disp;
  logic [1:0]          ret_num;
  logic                ret0;
  logic                ret1;

  assign head1 = head_q + IDX_W'(1);
  assign tail1 = tail_q + IDX_W'(1);

  // Dispatch grant: clamp the request to 2 and to the free space seen at the
  // start of the cycle; forced to zero while reset is held.
  always_comb begin
    req        = (bus.id_dispatch_num == 2'd3) ? 2'd2 : bus.id_dispatch_num;
    free_slots = SIZE_C - count_q;
    disp       = 2'd0;
    if (reset) begin
      if (free_slots >= (IDX_W+1)'(2)) begin
        disp = req;
      end else if (free_slots == (IDX_W+1)'(1) && req != 2'd0) begin
        disp = 2'd1;
      end
    end
  end

  // Retire selection from registered state only; head+1 retires only behind head.
  always_comb begin
    ret0    = valid_q[head_q] & complete_q[head_q];
    ret1    = ret0 & valid_q[head1] & complete_q[head1];
    ret_num = ret1 ? 2'd2 : (ret0 ? 2'd1 : 2'd0);
  end

  // Next entry state: completions first, then retire clears, then dispatch
  // writes so a same-index dispatch wins over a CDB write.
  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    if (bus.cdb_valid_a && valid_q[bus.cdb_idx_a]) complete_d[bus.cdb_idx_a] = 1'b1;
    if (bus.cdb_valid_b && valid_q[bus.cdb_idx_b]) complete_d[bus.cdb_idx_b] = 1'b1;
    if (ret0) begin
      valid_d[head_q]    = 1'b0;
      complete_d[head_q] = 1'b0;
    end
    if (ret1) begin
      valid_d[head1]    = 1'b0;
      complete_d[head1] = 1'b0;
    end
    if (disp != 2'd0) begin
      valid_d[tail_q]    = 1'b1;
      complete_d[tail_q] = 1'b0;
    end
    if (disp == 2'd2) begin
      valid_d[tail1]    = 1'b1;
      complete_d[tail1] = 1'b0;
    end
    head_d  = head_q + IDX_W'(ret_num);
    tail_d  = tail_q + IDX_W'(disp);
    count_d = count_q + (IDX_W+1)'(disp) - (IDX_W+1)'(ret_num);
  end

  // Control state with asynchronous clear of pointers, occupancy and flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      complete_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      complete_q <= complete_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Tag payload written on accepted slots; no reset needed since valid gates it.
  always_ff @(posedge clock) begin
    if (disp != 2'd0) begin
      new_tag_q[tail_q] <= bus.fl_tag_a;
      old_tag_q[tail_q] <= bus.mt_old_tag_a;
    end
    if (disp == 2'd2) begin
      new_tag_q[tail1] <= bus.fl_tag_b;
      old_tag_q[tail1] <= bus.mt_old_tag_b;
    end
  end

  assign bus.rob_dispatch_num = disp;
  assign bus.rob_idx_a        = tail_q;
  assign bus.rob_idx_b        = tail1;
  assign bus.rob_retire_num   = ret_num;
  assign bus.rob_retire_a     = ret0 ? old_tag_q[head_q] : '0;
  assign bus.rob_retire_b     = ret1 ? old_tag_q[head1] : '0;
  assign bus.rob_count        = count_q;
  assign bus.rob_full         = (count_q == SIZE_C);
  assign bus.rob_empty        = (count_q == '0);

endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed scenarios plus randomized traffic, checked against
// a queue-based model of the in-flight instruction window.
module tb_rob;
  localparam int RS = 32;
  localparam int IW = 5;
  localparam int TW = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;

  rob_if #(.IDX_W(IW), .TAG_W(TW)) bus ();

  rob #(.ROB_SIZE(RS), .IDX_W(IW), .TAG_W(TW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: program-ordered window of in-flight instructions.
  int q_idx[$];
  int q_old[$];
  bit q_cmp[$];
  int m_tail = 0;

  function automatic int e_disp();
    int rq, fr;
    rq = (bus.id_dispatch_num == 2'd3) ? 2 : int'(bus.id_dispatch_num);
    fr = RS - q_idx.size();
    if (!reset) return 0;
    return (rq < fr) ? rq : fr;
  endfunction

  function automatic int e_ret();
    if (q_idx.size() > 0 && q_cmp[0]) begin
      if (q_idx.size() > 1 && q_cmp[1]) return 2;
      return 1;
    end
    return 0;
  endfunction

  function automatic int e_ra();
    return (e_ret() >= 1) ? q_old[0] : 0;
  endfunction

  function automatic int e_rb();
    return (e_ret() == 2) ? q_old[1] : 0;
  endfunction

  task automatic model_clear();
    q_idx.delete();
    q_old.delete();
    q_cmp.delete();
    m_tail = 0;
  endtask

  task automatic set_idle();
    bus.id_dispatch_num = 2'd0;
    bus.fl_tag_a = '0;
    bus.fl_tag_b = '0;
    bus.mt_old_tag_a = '0;
    bus.mt_old_tag_b = '0;
    bus.cdb_valid_a = 1'b0;
    bus.cdb_valid_b = 1'b0;
    bus.cdb_idx_a = '0;
    bus.cdb_idx_b = '0;
  endtask

  // One clock: predict from the current inputs, advance the model at the edge.
  task automatic tick();
    int d, r, ia, ib, oa, ob;
    bit ca, cb;
    d  = e_disp();
    r  = e_ret();
    ca = bus.cdb_valid_a;
    cb = bus.cdb_valid_b;
    ia = int'(bus.cdb_idx_a);
    ib = int'(bus.cdb_idx_b);
    oa = int'(bus.mt_old_tag_a);
    ob = int'(bus.mt_old_tag_b);
    @(posedge clock);
    foreach (q_idx[i]) begin
      if (ca && q_idx[i] == ia) q_cmp[i] = 1'b1;
      if (cb && q_idx[i] == ib) q_cmp[i] = 1'b1;
    end
    repeat (r) begin
      void'(q_idx.pop_front());
      void'(q_old.pop_front());
      void'(q_cmp.pop_front());
    end
    if (d >= 1) begin
      q_idx.push_back(m_tail); q_old.push_back(oa); q_cmp.push_back(1'b0);
      m_tail = (m_tail + 1) % RS;
    end
    if (d == 2) begin
      q_idx.push_back(m_tail); q_old.push_back(ob); q_cmp.push_back(1'b0);
      m_tail = (m_tail + 1) % RS;
    end
    @(negedge clock);
  endtask

  // Complete and retire everything in flight (stimulus only).
  task automatic drain();
    int guard = 0;
    set_idle();
    while (q_idx.size() > 0 && guard < 100) begin
      bus.cdb_valid_a = 1'b1;
      bus.cdb_idx_a   = IW'(q_idx[0]);
      bus.cdb_valid_b = (q_idx.size() > 1);
      bus.cdb_idx_b   = (q_idx.size() > 1) ? IW'(q_idx[1]) : '0;
      tick();
      guard++;
    end
    set_idle();
  endtask

  task automatic test_reset();
    @(negedge clock);
    model_clear();
    set_idle();
    bus.id_dispatch_num = 2'd2;
    #1;
    total++; if (bus.rob_dispatch_num !== 2'd0) begin bad++; $display("FAIL rst_disp got=%0d want=0", bus.rob_dispatch_num); end
    total++; if (bus.rob_retire_num !== 2'd0) begin bad++; $display("FAIL rst_ret got=%0d want=0", bus.rob_retire_num); end
    total++; if (bus.rob_retire_a !== 7'd0 || bus.rob_retire_b !== 7'd0) begin bad++; $display("FAIL rst_rtags got=%0d/%0d want=0/0", bus.rob_retire_a, bus.rob_retire_b); end
    total++; if (bus.rob_empty !== 1'b1 || bus.rob_full !== 1'b0) begin bad++; $display("FAIL rst_flags got e=%b f=%b want e=1 f=0", bus.rob_empty, bus.rob_full); end
    total++; if (bus.rob_count !== 6'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.rob_count); end
    @(posedge clock); #1;
    total++; if (bus.rob_count !== 6'd0 || bus.rob_idx_a !== 5'd0) begin bad++; $display("FAIL rst_hold got cnt=%0d idx=%0d want 0/0", bus.rob_count, bus.rob_idx_a); end
    @(negedge clock);
    reset = 1'b1;
    set_idle();
  endtask

  task automatic test_basic();
    bus.id_dispatch_num = 2'd2;
    bus.fl_tag_a = 7'd32; bus.fl_tag_b = 7'd33;
    bus.mt_old_tag_a = 7'd1; bus.mt_old_tag_b = 7'd2;
    #1;
    total++; if (bus.rob_dispatch_num !== 2'd2) begin bad++; $display("FAIL basic_disp got=%0d want=2", bus.rob_dispatch_num); end
    total++; if (bus.rob_idx_a !== 5'd0 || bus.rob_idx_b !== 5'd1) begin bad++; $display("FAIL basic_idx got=%0d/%0d want=0/1", bus.rob_idx_a, bus.rob_idx_b); end
    tick();
    set_idle(); #1;
    total++; if (bus.rob_count !== 6'd2) begin bad++; $display("FAIL basic_count got=%0d want=2", bus.rob_count); end
    bus.cdb_valid_a = 1'b1; bus.cdb_idx_a = 5'd1;
    tick();
    bus.cdb_idx_a = 5'd0; #1;
    total++; if (bus.rob_retire_num !== 2'd0) begin bad++; $display("FAIL ooo_noret got=%0d want=0", bus.rob_retire_num); end
    tick();
    set_idle(); #1;
    total++; if (bus.rob_retire_num !== 2'd2) begin bad++; $display("FAIL ooo_ret got=%0d want=2", bus.rob_retire_num); end
    total++; if (bus.rob_retire_a !== 7'd1 || bus.rob_retire_b !== 7'd2) begin bad++; $display("FAIL ooo_tags got=%0d/%0d want=1/2", bus.rob_retire_a, bus.rob_retire_b); end
    tick(); #1;
    total++; if (bus.rob_count !== 6'd0 || bus.rob_empty !== 1'b1) begin bad++; $display("FAIL ooo_empty got cnt=%0d e=%b want 0/1", bus.rob_count, bus.rob_empty); end
    // Same-cycle dispatch and CDB to index 2: dispatch wins.
    bus.id_dispatch_num = 2'd1; bus.mt_old_tag_a = 7'd5;
    bus.cdb_valid_a = 1'b1; bus.cdb_idx_a = 5'd2; #1;
    total++; if (bus.rob_dispatch_num !== 2'd1 || bus.rob_idx_a !== 5'd2) begin bad++; $display("FAIL race_disp got=%0d idx=%0d want 1/2", bus.rob_dispatch_num, bus.rob_idx_a); end
    tick();
    set_idle(); #1;
    total++; if (bus.rob_retire_num !== 2'd0) begin bad++; $display("FAIL race_ret got=%0d want=0", bus.rob_retire_num); end
    bus.cdb_valid_a = 1'b1; bus.cdb_idx_a = 5'd2;
    tick();
    set_idle(); #1;
    total++; if (bus.rob_retire_num !== 2'd1 || bus.rob_retire_a !== 7'd5) begin bad++; $display("FAIL race_ret2 got=%0d tag=%0d want 1/5", bus.rob_retire_num, bus.rob_retire_a); end
    tick();
  endtask

  task automatic test_full();
    int era;
    for (int i = 0; i < 16; i++) begin
      bus.id_dispatch_num = (i < 15) ? 2'd2 : 2'd1;
      bus.mt_old_tag_a = TW'($urandom_range(0, 95));
      bus.mt_old_tag_b = TW'($urandom_range(0, 95));
      tick();
    end
    #1;
    total++; if (bus.rob_count !== 6'd31) begin bad++; $display("FAIL fill_count got=%0d want=31", bus.rob_count); end
    bus.id_dispatch_num = 2'd2; #1;
    total++; if (bus.rob_dispatch_num !== 2'd1) begin bad++; $display("FAIL full_last got=%0d want=1", bus.rob_dispatch_num); end
    tick(); #1;
    total++; if (bus.rob_full !== 1'b1 || bus.rob_count !== 6'd32) begin bad++; $display("FAIL full_flag got f=%b cnt=%0d want 1/32", bus.rob_full, bus.rob_count); end
    total++; if (bus.rob_dispatch_num !== 2'd0) begin bad++; $display("FAIL full_nodisp got=%0d want=0", bus.rob_dispatch_num); end
    bus.id_dispatch_num = 2'd0;
    bus.cdb_valid_a = 1'b1; bus.cdb_idx_a = IW'(q_idx[0]);
    tick();
    set_idle(); bus.id_dispatch_num = 2'd2; #1;
    era = q_old[0];
    total++; if (bus.rob_retire_num !== 2'd1 || bus.rob_dispatch_num !== 2'd0) begin bad++; $display("FAIL full_ret got ret=%0d disp=%0d want 1/0", bus.rob_retire_num, bus.rob_dispatch_num); end
    total++; if (bus.rob_retire_a !== TW'(era)) begin bad++; $display("FAIL full_rtag got=%0d want=%0d", bus.rob_retire_a, era); end
    tick(); #1;
    total++; if (bus.rob_dispatch_num !== 2'd1) begin bad++; $display("FAIL full_after got=%0d want=1", bus.rob_dispatch_num); end
    tick();
    drain(); #1;
    total++; if (bus.rob_count !== 6'd0) begin bad++; $display("FAIL full_drain got=%0d want=0", bus.rob_count); end
  endtask

  task automatic test_wrap();
    int prev;
    bit wrapped, have_prev;
    wrapped = 1'b0; have_prev = 1'b0; prev = 0;
    for (int k = 0; k < 42; k++) begin
      set_idle();
      bus.id_dispatch_num = 2'd1;
      bus.mt_old_tag_a = TW'($urandom_range(0, 95));
      if (have_prev) begin bus.cdb_valid_a = 1'b1; bus.cdb_idx_a = IW'(prev); end
      #1;
      total++; if (bus.rob_idx_a !== IW'(m_tail) || bus.rob_dispatch_num !== 2'(e_disp())) begin bad++; $display("FAIL wrap_disp k=%0d got idx=%0d n=%0d want %0d/%0d", k, bus.rob_idx_a, bus.rob_dispatch_num, m_tail, e_disp()); end
      total++; if (bus.rob_retire_num !== 2'(e_ret()) || bus.rob_retire_a !== TW'(e_ra())) begin bad++; $display("FAIL wrap_ret k=%0d got n=%0d tag=%0d want %0d/%0d", k, bus.rob_retire_num, bus.rob_retire_a, e_ret(), e_ra()); end
      if (k >= 2) begin
        total++; if (bus.rob_count !== 6'd2) begin bad++; $display("FAIL wrap_count k=%0d got=%0d want=2", k, bus.rob_count); end
      end
      if (have_prev && prev == RS - 1 && bus.rob_idx_a === 5'd0) wrapped = 1'b1;
      prev = int'(bus.rob_idx_a);
      have_prev = 1'b1;
      tick();
    end
    total++; if (!wrapped) begin bad++; $display("FAIL wrap_seen got=0 want=1"); end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bus.id_dispatch_num = 2'($urandom_range(0, 3));
      bus.fl_tag_a = TW'($urandom_range(0, 95));
      bus.fl_tag_b = TW'($urandom_range(0, 95));
      bus.mt_old_tag_a = TW'($urandom_range(0, 95));
      bus.mt_old_tag_b = TW'($urandom_range(0, 95));
      bus.cdb_valid_a = ($urandom_range(0, 1) == 1);
      bus.cdb_valid_b = ($urandom_range(0, 2) == 0);
      if (q_idx.size() > 0 && $urandom_range(0, 9) < 7) begin
        bus.cdb_idx_a = IW'(q_idx[$urandom_range(0, q_idx.size() - 1)]);
        bus.cdb_idx_b = IW'(q_idx[$urandom_range(0, q_idx.size() - 1)]);
      end else begin
        bus.cdb_idx_a = IW'($urandom_range(0, RS - 1));
        bus.cdb_idx_b = IW'($urandom_range(0, RS - 1));
      end
      #1;
      total++; if (bus.rob_dispatch_num !== 2'(e_disp())) begin bad++; $display("FAIL rnd_disp k=%0d got=%0d want=%0d", k, bus.rob_dispatch_num, e_disp()); end
      total++; if (bus.rob_idx_a !== IW'(m_tail) || bus.rob_idx_b !== IW'((m_tail + 1) % RS)) begin bad++; $display("FAIL rnd_idx k=%0d got=%0d/%0d want=%0d/%0d", k, bus.rob_idx_a, bus.rob_idx_b, m_tail, (m_tail + 1) % RS); end
      total++; if (bus.rob_retire_num !== 2'(e_ret())) begin bad++; $display("FAIL rnd_ret k=%0d got=%0d want=%0d", k, bus.rob_retire_num, e_ret()); end
      total++; if (bus.rob_retire_a !== TW'(e_ra()) || bus.rob_retire_b !== TW'(e_rb())) begin bad++; $display("FAIL rnd_rtags k=%0d got=%0d/%0d want=%0d/%0d", k, bus.rob_retire_a, bus.rob_retire_b, e_ra(), e_rb()); end
      total++; if (bus.rob_count !== 6'(q_idx.size()) || bus.rob_full !== (q_idx.size() == RS) || bus.rob_empty !== (q_idx.size() == 0)) begin bad++; $display("FAIL rnd_occ k=%0d got cnt=%0d f=%b e=%b want cnt=%0d", k, bus.rob_count, bus.rob_full, bus.rob_empty, q_idx.size()); end
      tick();
    end
    drain(); #1;
    total++; if (bus.rob_empty !== 1'b1) begin bad++; $display("FAIL rnd_drain got=%b want=1", bus.rob_empty); end
  endtask

  task automatic test_reset_mid();
    set_idle();
    for (int i = 0; i < 5; i++) begin
      bus.id_dispatch_num = 2'd2;
      bus.mt_old_tag_a = TW'(10 + i);
      bus.mt_old_tag_b = TW'(20 + i);
      tick();
    end
    set_idle();
    bus.cdb_valid_a = 1'b1; bus.cdb_idx_a = IW'(q_idx[0]);
    tick();
    set_idle(); #1;
    total++; if (bus.rob_count !== 6'd10 || bus.rob_retire_num !== 2'd1) begin bad++; $display("FAIL mid_pre got cnt=%0d ret=%0d want 10/1", bus.rob_count, bus.rob_retire_num); end
    bus.id_dispatch_num = 2'd2;
    reset = 1'b0;
    model_clear();
    #1;
    total++; if (bus.rob_count !== 6'd0 || bus.rob_empty !== 1'b1 || bus.rob_full !== 1'b0) begin bad++; $display("FAIL mid_occ got cnt=%0d e=%b f=%b want 0/1/0", bus.rob_count, bus.rob_empty, bus.rob_full); end
    total++; if (bus.rob_retire_num !== 2'd0 || bus.rob_retire_a !== 7'd0 || bus.rob_dispatch_num !== 2'd0) begin bad++; $display("FAIL mid_out got ret=%0d tag=%0d disp=%0d want 0/0/0", bus.rob_retire_num, bus.rob_retire_a, bus.rob_dispatch_num); end
    tick();
    reset = 1'b1;
    set_idle();
    bus.id_dispatch_num = 2'd1; bus.mt_old_tag_a = 7'd9; #1;
    total++; if (bus.rob_idx_a !== 5'd0 || bus.rob_dispatch_num !== 2'd1) begin bad++; $display("FAIL mid_first got idx=%0d n=%0d want 0/1", bus.rob_idx_a, bus.rob_dispatch_num); end
    tick();
    set_idle(); #1;
    total++; if (bus.rob_count !== 6'd1) begin bad++; $display("FAIL mid_count got=%0d want=1", bus.rob_count); end
    drain();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
